// File: rtl/ascon_result_serializer.sv
// Ascon-128 result serializer: starts the core, captures {ciphertext, tag}, streams it MSW-first; ASCON_SER_TIMEOUT_EN adds a done watchdog.
// Latency: enc_start one cycle after op accept; first word one cycle after enc_done is sampled, then WORDS words.
// Backpressure: out_data/out_last/out_valid hold while out_ready is low; op_ready stays low until the core leaves done.
module ascon_result_serializer #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [127:0]      enc_ciphertext,
  input  logic [127:0]      enc_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              err
);

  localparam int WORDS = 256 / DATA_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    SEND,
    RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [255:0]     sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             tmo_hit;

`ifdef ASCON_SER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts completed WAIT_DONE cycles; the TIMEOUT_CYC-th one without done aborts.
  assign tmo_hit = (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign op_ready  = (state_q == IDLE) && !enc_done;
  assign enc_start = start_q;
  assign out_valid = valid_q;
  assign out_data  = sr_q[255 -: DATA_W];
  assign out_last  = valid_q && (idx_q == LAST_IDX);
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    start_d = start_q;
    valid_d = valid_q;
    err_d   = err_q;
`ifdef ASCON_SER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          start_d = 1'b1;
          err_d   = 1'b0;
          state_d = WAIT_DONE;
`ifdef ASCON_SER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (enc_done) begin
          sr_d    = {enc_ciphertext, enc_tag};
          start_d = 1'b0;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = SEND;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end
`ifdef ASCON_SER_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      SEND: begin
        if (valid_q && out_ready) begin
          // Shifting on the last word too leaves sr all-zero, so idle out_data reads 0.
          sr_d = sr_q << DATA_W;
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            state_d = RELEASE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RELEASE: begin
        // Hold off until the core has seen start low and left its done state.
        if (!enc_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ASCON_SER_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef ASCON_SER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: doc/ascon_result_serializer.md
# ascon_result_serializer

Downstream companion of the Ascon-128 encryption core. It issues `start` to the core for each requested operation and captures the 128-bit `ciphertext` and 128-bit `tag` when the core raises `done`. It then releases `start` so the core returns to idle, and streams the 256-bit result as narrow words over a valid/ready interface toward the output DMA/UART path.

## Interface
Parameters:
- `DATA_W`, default 32: output word width. Legal values are 32, 64 and 128. `WORDS = 256/DATA_W`.
- `TIMEOUT_CYC`, default 1023: watchdog limit in cycles. Used only when `ASCON_SER_TIMEOUT_EN` is defined.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `op_valid`, in, 1: request one encryption. Core inputs `key`/`nonce`/`plaintext` are held stable externally.
- `op_ready`, out, 1: block can accept a request.
- `enc_start`, out, 1: drives the core's `start`.
- `enc_done`, in, 1: the core's `done`.
- `enc_ciphertext`, in, 128: the core's `ciphertext`.
- `enc_tag`, in, 128: the core's `tag`.
- `out_data`, out, DATA_W: result word.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: sink accepts the word.
- `out_last`, out, 1: final word of the 256-bit result.
- `err`, out, 1: watchdog expired. This port is always present and tied 0 when the feature is compiled out.

## Operation
- State machine has four states: IDLE, WAIT_DONE, SEND, RELEASE.
- **IDLE**
  - `op_ready = !enc_done`.
  - On `op_valid && op_ready`: `enc_start <= 1`, clear `err`, go to WAIT_DONE.
- **WAIT_DONE**
  - `enc_start` is held high.
  - When `enc_done==1`:
    - load the shift register: `sr <= {enc_ciphertext, enc_tag}`, so ciphertext occupies bits [255:128];
    - `enc_start <= 0`;
    - `idx <= 0`;
    - `out_valid <= 1`;
    - go to SEND.
- **SEND**
  - `out_data = sr[255 -: DATA_W]`, so words go out MSW-first: ciphertext first, then tag.
  - On `out_valid && out_ready`:
    - shift `sr` left by DATA_W;
    - increment `idx`;
    - if `idx==WORDS-1`: `out_valid <= 0`, go to RELEASE.
  - `out_last = out_valid && (idx==WORDS-1)`.
- **RELEASE**
  - Wait for `enc_done==0`, which the core produces after seeing `start` low, then go to IDLE.
  - Prevents re-triggering the core while it still sits in its done state.
- Only one operation is in flight. No queueing. `op_valid` is ignored outside IDLE.
- `idx` width is `$clog2(WORDS)`. It never wraps past WORDS-1 within an operation.

## Timing
- Reset values:
  - `enc_start=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `err=0`;
  - state IDLE;
  - `op_ready=1` if `enc_done=0`.
- Request accepted in cycle N: `enc_start=1` in N+1.
- `enc_done` sampled high in cycle M:
  - `enc_start=0` and `out_valid=1` in M+1;
  - first word visible in M+1.
- With `out_ready` tied high: one word per cycle, WORDS cycles. `out_last` is in cycle M+WORDS.
- While `out_valid && !out_ready`: `out_data`, `out_last` and `out_valid` hold stable.
- `op_ready` rises no earlier than the cycle after RELEASE observes `enc_done==0`.
- Reset mid-operation:
  - all outputs return to reset values on the next edge;
  - `enc_start` drops, and the core returns to idle on its own handshake;
  - a subsequent request waits for `enc_done==0`.
- If `enc_done` is already high on entering WAIT_DONE (stale), it is captured. Prevented by design, because IDLE requires `enc_done==0`.

## Configuration
- **`ASCON_SER_TIMEOUT_EN` defined:**
  - a counter runs in WAIT_DONE, cleared on entry;
  - if it reaches `TIMEOUT_CYC` without `enc_done`: `err <= 1`, `enc_start <= 0`, go to RELEASE, and no words are emitted;
  - `err` stays high until the next accepted request.
- **Not defined:** no counter. WAIT_DONE waits indefinitely. `err` is constant 0.

## Test plan
1. **Basic stream.**
   - Stimulus: core returns ct=`00112233_44556677_8899AABB_CCDDEEFF`, tag=`A0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3`, `out_ready=1`, DATA_W=32.
   - Required: 8 consecutive words `00112233`, `44556677`, …, `D0D1D2D3`; `out_last` only on `D0D1D2D3`.
2. **Backpressure.**
   - Stimulus: toggle `out_ready` 1,0,0,1 repeatedly.
   - Required: the same 8 words in order, `out_data` stable during stalls, no duplicates or drops.
3. **Start/done handshake.**
   - Required: `enc_start` is high from the cycle after acceptance until the cycle after `enc_done` rises.
   - Required: `op_ready` stays 0 until `enc_done` has fallen.
   - Required: a second `op_valid` issued during SEND is ignored.
4. **DATA_W=64.**
   - Required: 4 words `0011223344556677`, …, `C0C1C2C3D0D1D2D3`, with `out_last` on the 4th.
5. **Reset mid-SEND.**
   - Stimulus: assert `rst` after word 3.
   - Required: next cycle `out_valid=0`, `enc_start=0`, `err=0`, state IDLE.
   - Required: a new request then yields a full 8-word stream.
6. **Timeout, with `ASCON_SER_TIMEOUT_EN` and `TIMEOUT_CYC=16`.**
   - Stimulus: hold `enc_done=0`.
   - Required: `err=1` and `enc_start=0` about 16 cycles after `enc_start` rises, and no `out_valid`.
   - Required: the next accepted request clears `err`.
